riscv_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous unified memory between the IF-stage fetch port and the MM-stage load/store port of the pipelined core.

---
 rtl/riscv_mem_arbiter_if.sv | 61 ++++++
 rtl/riscv_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter_if
//   Bundles the three buses that meet at the unified-memory arbiter:
//     - IF fetch port    : read-only request/grant plus tagged read return
//     - MM data port     : load/store request/grant plus tagged read return
//     - memory port      : single-port synchronous RAM command + read data
//   Signal names keep the arbiter's point of view (i_ = into the arbiter,
//   o_ = out of the arbiter) so that both sides read the same way.
//
//   Modports
//     slave  : the arbiter itself
//     master : the environment (core stages + memory) driving the arbiter
// ---------------------------------------------------------------------------
interface riscv_mem_arbiter_if #(
    parameter int XLEN = 32
) ();

    // IF-stage fetch port
    logic            i_arb_if_req;
    logic [XLEN-1:0] i_arb_if_addr;
    logic            o_arb_if_gnt;
    logic            o_arb_if_rvalid;
    logic [XLEN-1:0] o_arb_if_rdata;

    // MM-stage load/store port
    logic            i_arb_mm_req;
    logic            i_arb_mm_wen;
    logic [3:0]      i_arb_mm_strb;
    logic [XLEN-1:0] i_arb_mm_addr;
    logic [XLEN-1:0] i_arb_mm_wdata;
    logic            o_arb_mm_gnt;
    logic            o_arb_mm_rvalid;
    logic [XLEN-1:0] o_arb_mm_rdata;

    // Unified memory port
    logic            o_arb_mem_cs;
    logic            o_arb_mem_wen;
    logic [3:0]      o_arb_mem_strb;
    logic [XLEN-1:0] o_arb_mem_addr;
    logic [XLEN-1:0] o_arb_mem_wdata;
    logic [XLEN-1:0] i_arb_mem_rdata;

    modport slave (
        input  i_arb_if_req, i_arb_if_addr,
        output o_arb_if_gnt, o_arb_if_rvalid, o_arb_if_rdata,
        input  i_arb_mm_req, i_arb_mm_wen, i_arb_mm_strb, i_arb_mm_addr, i_arb_mm_wdata,
        output o_arb_mm_gnt, o_arb_mm_rvalid, o_arb_mm_rdata,
        output o_arb_mem_cs, o_arb_mem_wen, o_arb_mem_strb, o_arb_mem_addr, o_arb_mem_wdata,
        input  i_arb_mem_rdata
    );

    modport master (
        output i_arb_if_req, i_arb_if_addr,
        input  o_arb_if_gnt, o_arb_if_rvalid, o_arb_if_rdata,
        output i_arb_mm_req, i_arb_mm_wen, i_arb_mm_strb, i_arb_mm_addr, i_arb_mm_wdata,
        input  o_arb_mm_gnt, o_arb_mm_rvalid, o_arb_mm_rdata,
        input  o_arb_mem_cs, o_arb_mem_wen, o_arb_mem_strb, o_arb_mem_addr, o_arb_mem_wdata,
        output i_arb_mem_rdata
    );

endinterface

// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
//   Shares one single-port synchronous unified memory between the IF-stage
//   fetch port and the MM-stage load/store port. At most one access is
//   granted per cycle (combinational grant); the loser sees gnt=0 and its
//   stage stalls. Read data returns one cycle after grant, steered to the
//   port that issued the read, and each port holds its last read word until
//   its next read returns. A starvation counter flips priority to IF after
//   STARVE_MAX consecutive denied fetch cycles so fetch always progresses.
//
// Parameters
//   XLEN        data/address width
//   STARVE_MAX  consecutive denied IF cycles before IF gets priority (1..15)
//
// Ports
//   i_clk   clock, all state on rising edge
//   i_rstn  synchronous active-low reset
//   bus     riscv_mem_arbiter_if.slave: IF port, MM port, memory port
// ---------------------------------------------------------------------------
module riscv_mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    riscv_mem_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {
        PRIO_MM = 1'b0,
        PRIO_IF = 1'b1
    } prio_e;

    // Who owns the read data arriving from memory this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MM   = 2'd2
    } owner_e;

    prio_e           state_q, state_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    owner_e          owner_q, owner_d;
    logic [XLEN-1:0] hold_if_q, hold_if_d;
    logic [XLEN-1:0] hold_mm_q, hold_mm_d;

    logic            if_gnt;
    logic            mm_gnt;
    logic            if_denied;
    logic            if_rvalid;
    logic            mm_rvalid;

    // -----------------------------------------------------------------------
    // Grant: single requester always wins; on conflict the priority state
    // decides. Everything is gated by reset so the memory is never touched
    // while the core is held in reset.
    // -----------------------------------------------------------------------
    always_comb begin
        if_gnt = 1'b0;
        mm_gnt = 1'b0;
        if (i_rstn) begin
            if (bus.i_arb_if_req && bus.i_arb_mm_req) begin
                if (state_q == PRIO_IF) begin
                    if_gnt = 1'b1;
                end else begin
                    mm_gnt = 1'b1;
                end
            end else begin
                if_gnt = bus.i_arb_if_req;
                mm_gnt = bus.i_arb_mm_req;
            end
        end
    end

    assign if_denied = bus.i_arb_if_req && !if_gnt;

    // -----------------------------------------------------------------------
    // Priority FSM and starvation counter (next state).
    // The counter tracks consecutive denied fetch cycles; the denial that
    // would bring it to STARVE_MAX is the one that hands priority to IF, so
    // the very next conflicting cycle goes to fetch. Any IF grant returns
    // priority to MM, which keeps loads/stores fast in the common case.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;

        if (if_denied) begin
            if (starve_cnt_q != STARVE_LIM) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
            if ((state_q == PRIO_MM) && (starve_cnt_q + 4'd1 == STARVE_LIM)) begin
                state_d = PRIO_IF;
            end
        end else begin
            starve_cnt_d = 4'd0;
        end

        if (if_gnt) begin
            state_d = PRIO_MM;
        end
    end

    // -----------------------------------------------------------------------
    // Read return tagging. A granted read records its owner so the data
    // arriving next cycle is steered to the right port; stores record
    // nothing. The owner's hold register captures the word on the same
    // cycle it is presented, so the value stays visible afterwards.
    // -----------------------------------------------------------------------
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (mm_gnt && !bus.i_arb_mm_wen) begin
            owner_d = OWN_MM;
        end
    end

    assign if_rvalid = (owner_q == OWN_IF);
    assign mm_rvalid = (owner_q == OWN_MM);

    always_comb begin
        hold_if_d = hold_if_q;
        hold_mm_d = hold_mm_q;
        if (if_rvalid) begin
            hold_if_d = bus.i_arb_mem_rdata;
        end
        if (mm_rvalid) begin
            hold_mm_d = bus.i_arb_mem_rdata;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= PRIO_MM;
            starve_cnt_q <= 4'd0;
            owner_q      <= OWN_NONE;
            hold_if_q    <= '0;
            hold_mm_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            hold_if_q    <= hold_if_d;
            hold_mm_q    <= hold_mm_d;
        end
    end

    // -----------------------------------------------------------------------
    // Memory command mux. IF is read-only, so its grant forces the write
    // side to zero rather than letting stale MM store fields leak through.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.o_arb_mem_cs    = if_gnt || mm_gnt;
        bus.o_arb_mem_wen   = 1'b0;
        bus.o_arb_mem_strb  = 4'b0000;
        bus.o_arb_mem_addr  = '0;
        bus.o_arb_mem_wdata = '0;
        if (mm_gnt) begin
            bus.o_arb_mem_wen   = bus.i_arb_mm_wen;
            bus.o_arb_mem_strb  = bus.i_arb_mm_strb;
            bus.o_arb_mem_addr  = bus.i_arb_mm_addr;
            bus.o_arb_mem_wdata = bus.i_arb_mm_wdata;
        end else if (if_gnt) begin
            bus.o_arb_mem_addr  = bus.i_arb_if_addr;
        end
    end

    // -----------------------------------------------------------------------
    // Port outputs. Live memory data is forwarded in the return cycle; the
    // hold register covers every other cycle.
    // -----------------------------------------------------------------------
    assign bus.o_arb_if_gnt    = if_gnt;
    assign bus.o_arb_mm_gnt    = mm_gnt;
    assign bus.o_arb_if_rvalid = if_rvalid;
    assign bus.o_arb_mm_rvalid = mm_rvalid;
    assign bus.o_arb_if_rdata  = if_rvalid ? bus.i_arb_mem_rdata : hold_if_q;
    assign bus.o_arb_mm_rdata  = mm_rvalid ? bus.i_arb_mem_rdata : hold_mm_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riscv_mem_arbiter
//   Directed scenarios followed by constrained-random traffic. A behavioural
//   memory answers the arbiter's memory port; a reference model tracks
//   priority, consecutive fetch denials, pending read returns and the per-
//   port held data, and every cycle's outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_riscv_mem_arbiter;

    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic rstn;

    riscv_mem_arbiter_if #(.XLEN(XLEN)) bus ();

    riscv_mem_arbiter #(
        .XLEN      (XLEN),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: 256 words, one-cycle read latency. Only the
    // stimulus process writes the array; this block only reads it. Cycles
    // without a read return random garbage so held data is really tested.
    logic [31:0] mem_arr [0:255];

    always @(posedge clk) begin
        if (bus.o_arb_mem_cs && !bus.o_arb_mem_wen)
            bus.i_arb_mem_rdata <= mem_arr[bus.o_arb_mem_addr[9:2]];
        else
            bus.i_arb_mem_rdata <= $urandom;
    end

    // Counters
    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          known = 0;       // model valid once a reset edge has happened
    bit          m_prio_if;       // IF wins conflicts
    int          m_denied;        // consecutive denied fetch cycles
    bit          m_pend_if, m_pend_mm;
    logic [31:0] m_pend_data;
    logic [31:0] m_hold_if, m_hold_mm;
    bit          m_last_gi;

    // Sampled DUT outputs from the latest cycle (for directed checks)
    logic        obs_if_gnt, obs_mm_gnt, obs_cs, obs_wen;
    logic        obs_if_rvalid, obs_mm_rvalid;
    logic [3:0]  obs_strb;
    logic [31:0] obs_if_rdata, obs_mm_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, sample just before the next edge, compare
    // against the model, then advance the model across that edge.
    task automatic cycle(input bit rv, input bit ir, input logic [31:0] ia,
                         input bit mr, input bit mw, input logic [3:0] ms,
                         input logic [31:0] ma, input logic [31:0] md);
        bit          eg_if, eg_mm;
        logic [31:0] eaddr, widx_addr;
        logic [31:0] old_word, new_word;
        @(posedge clk);
        #1;
        rstn                = rv;
        bus.i_arb_if_req    = ir;
        bus.i_arb_if_addr   = ia;
        bus.i_arb_mm_req    = mr;
        bus.i_arb_mm_wen    = mw;
        bus.i_arb_mm_strb   = ms;
        bus.i_arb_mm_addr   = ma;
        bus.i_arb_mm_wdata  = md;
        #3;

        if (!rv) begin
            eg_if = 0; eg_mm = 0;
        end else if (ir && mr) begin
            eg_if = m_prio_if; eg_mm = !m_prio_if;
        end else begin
            eg_if = ir; eg_mm = mr;
        end
        eaddr = eg_mm ? ma : ia;

        obs_if_gnt    = bus.o_arb_if_gnt;
        obs_mm_gnt    = bus.o_arb_mm_gnt;
        obs_cs        = bus.o_arb_mem_cs;
        obs_wen       = bus.o_arb_mem_wen;
        obs_strb      = bus.o_arb_mem_strb;
        obs_if_rvalid = bus.o_arb_if_rvalid;
        obs_mm_rvalid = bus.o_arb_mm_rvalid;
        obs_if_rdata  = bus.o_arb_if_rdata;
        obs_mm_rdata  = bus.o_arb_mm_rdata;

        check("if_gnt", 32'(obs_if_gnt), 32'(eg_if));
        check("mm_gnt", 32'(obs_mm_gnt), 32'(eg_mm));
        check("mem_cs", 32'(obs_cs), 32'(eg_if | eg_mm));
        check("mem_wen", 32'(obs_wen), 32'(eg_mm & mw));
        check("mem_strb", 32'(obs_strb), eg_mm ? 32'(ms) : 32'd0);
        if (eg_if || eg_mm) begin
            check("mem_addr", bus.o_arb_mem_addr, eaddr);
            check("mem_wdata", bus.o_arb_mem_wdata, eg_mm ? md : 32'd0);
        end
        if (known) begin
            check("if_rvalid", 32'(obs_if_rvalid), 32'(m_pend_if));
            check("mm_rvalid", 32'(obs_mm_rvalid), 32'(m_pend_mm));
            check("if_rdata", obs_if_rdata, m_pend_if ? m_pend_data : m_hold_if);
            check("mm_rdata", obs_mm_rdata, m_pend_mm ? m_pend_data : m_hold_mm);
        end

        // Advance model across the edge
        m_last_gi = eg_if;
        if (!rv) begin
            known     = 1;
            m_prio_if = 0;
            m_denied  = 0;
            m_pend_if = 0;
            m_pend_mm = 0;
            m_hold_if = '0;
            m_hold_mm = '0;
        end else begin
            if (m_pend_if) m_hold_if = m_pend_data;
            if (m_pend_mm) m_hold_mm = m_pend_data;
            m_pend_if   = eg_if;
            m_pend_mm   = eg_mm && !mw;
            m_pend_data = mem_arr[eaddr[9:2]];
            if (eg_mm && mw) begin
                widx_addr = ma;
                old_word  = mem_arr[widx_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    new_word[b*8 +: 8] = ms[b] ? md[b*8 +: 8] : old_word[b*8 +: 8];
                mem_arr[widx_addr[9:2]] = new_word;
            end
            if (ir && !eg_if) begin
                m_denied++;
                if (m_denied >= STARVE_MAX) m_prio_if = 1;
            end else begin
                m_denied = 0;
            end
            if (eg_if) m_prio_if = 0;
        end
        $display("cyc rst=%0d ifreq=%0d mmreq=%0d wen=%0d gnt=%0d%0d rv=%0d%0d", !rv, ir, mr, mw,
                 obs_if_gnt, obs_mm_gnt, obs_if_rvalid, obs_mm_rvalid);
    endtask

    task automatic idle();
        cycle(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    logic [31:0] exp_word;
    logic [31:0] waddr;
    bit          r_ir, r_mr, r_mw;
    logic [31:0] r_ia, r_ma, r_md;
    logic [3:0]  r_ms;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
        mem_arr[64] = 32'h0000_0013;         // fetch word at 0x100
        rstn = 1'b0;
        bus.i_arb_if_req = 0; bus.i_arb_if_addr = '0;
        bus.i_arb_mm_req = 0; bus.i_arb_mm_wen = 0; bus.i_arb_mm_strb = '0;
        bus.i_arb_mm_addr = '0; bus.i_arb_mm_wdata = '0;

        // 1. Reset with both requests high
        cycle(0, 1, 32'h100, 1, 0, 4'h0, 32'h200, 32'h0);
        cycle(0, 1, 32'h100, 1, 0, 4'h0, 32'h200, 32'h0);
        check("rst_if_gnt", 32'(obs_if_gnt), 32'd0);
        check("rst_mm_gnt", 32'(obs_mm_gnt), 32'd0);
        check("rst_cs", 32'(obs_cs), 32'd0);

        // 2. Fetch only
        cycle(1, 1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0);
        check("t2_if_gnt", 32'(obs_if_gnt), 32'd1);
        idle();
        check("t2_if_rvalid", 32'(obs_if_rvalid), 32'd1);
        check("t2_if_rdata", obs_if_rdata, 32'h13);
        idle();
        check("t2_if_rvalid_off", 32'(obs_if_rvalid), 32'd0);
        check("t2_if_hold", obs_if_rdata, 32'h13);

        // 3. Conflict, MM store wins under PRIO_MM
        cycle(1, 1, 32'h100, 1, 1, 4'b0011, 32'h200, 32'hDEADBEEF);
        check("t3_mm_gnt", 32'(obs_mm_gnt), 32'd1);
        check("t3_if_gnt", 32'(obs_if_gnt), 32'd0);
        check("t3_wen", 32'(obs_wen), 32'd1);
        check("t3_strb", 32'(obs_strb), 32'h3);
        idle();
        check("t3_no_mm_rvalid", 32'(obs_mm_rvalid), 32'd0);

        // 4. Starvation: IF denied STARVE_MAX cycles, granted next, then PRIO_MM
        for (int k = 0; k <= STARVE_MAX; k++) begin
            cycle(1, 1, 32'h100, 1, 0, 4'h0, 32'h204, 32'h0);
            check("t4_if_gnt", 32'(obs_if_gnt), (k == STARVE_MAX) ? 32'd1 : 32'd0);
        end
        cycle(1, 1, 32'h100, 1, 0, 4'h0, 32'h204, 32'h0);
        check("t4_back_to_mm", 32'(obs_mm_gnt), 32'd1);
        idle();

        // 5. Alternating IF then MM load
        cycle(1, 1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0);
        exp_word = mem_arr[130];             // word at 0x208
        cycle(1, 0, 32'h0, 1, 0, 4'h0, 32'h208, 32'h0);
        check("t5_if_rvalid", 32'(obs_if_rvalid), 32'd1);
        check("t5_mm_rvalid_early", 32'(obs_mm_rvalid), 32'd0);
        idle();
        check("t5_mm_rvalid", 32'(obs_mm_rvalid), 32'd1);
        check("t5_if_rvalid_off", 32'(obs_if_rvalid), 32'd0);
        check("t5_mm_rdata", obs_mm_rdata, exp_word);

        // 6. Reset right after a read grant
        cycle(1, 1, 32'h104, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        idle();
        check("t6_if_rvalid", 32'(obs_if_rvalid), 32'd0);
        check("t6_if_hold0", obs_if_rdata, 32'd0);
        check("t6_mm_hold0", obs_mm_rdata, 32'd0);
        for (int k = 0; k <= STARVE_MAX; k++) begin
            cycle(1, 1, 32'h100, 1, 0, 4'h0, 32'h20C, 32'h0);
            check("t6_starve_restart", 32'(obs_if_gnt), (k == STARVE_MAX) ? 32'd1 : 32'd0);
        end

        // Random traffic; an ungranted fetch usually keeps its request
        r_ir = 0;
        m_last_gi = 1;
        for (int n = 0; n < 600; n++) begin
            if (!(r_ir && !m_last_gi) || $urandom_range(0, 7) == 0) begin
                r_ir = ($urandom_range(0, 3) != 0);
                waddr = 32'($urandom_range(0, 255)) << 2;
                r_ia = waddr;
            end
            r_mr  = ($urandom_range(0, 2) != 0);
            r_mw  = ($urandom_range(0, 2) == 0);
            r_ms  = 4'($urandom_range(0, 15));
            waddr = 32'($urandom_range(0, 255)) << 2;
            r_ma  = waddr;
            r_md  = $urandom;
            cycle(($urandom_range(0, 59) != 0), r_ir, r_ia, r_mr, r_mw, r_ms, r_ma, r_md);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
